clock_divider_bank: RTL and testbench
=====================================

# clock_divider_bank

Parametrised bank of independent clock dividers, successor to the single fixed-ratio divider used for the VGA and debounce clocks. Each channel produces a 50 % square wave and single-cycle tick strobes from the system clock. Each channel has a divisor and enable that software or control FSMs can change at runtime. New divisors are applied glitch-free at half-period boundaries through a per-channel shadow register and a valid/ready configuration port.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 28, divisor/counter width in bits
- DEFAULT_DIV, 25000000, divisor loaded into every channel at reset (half period = DEFAULT_DIV+1 cycles)
- DEFAULT_EN, 1, enable state of every channel at reset
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; asserting it immediately forces every register to its reset value
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  combinational; = !pending[cfg_chan]
- cfg_chan  in  $clog2(CHANNELS) (min 1)  target channel
- cfg_div  in  WIDTH  new divisor
- cfg_en  in  1  new enable
- clk_out  out  CHANNELS  divided square waves, registered
- tick_half  out  CHANNELS  1-cycle pulse on every clk_out toggle
- tick_rise  out  CHANNELS  1-cycle pulse on every clk_out 0->1 toggle
- pending  out  CHANNELS  shadow update waiting for boundary

## Operation
- Per-channel state: cnt[WIDTH], div_q[WIDTH], en_q, shadow_div[WIDTH], pending.
- Reset: cnt=0, div_q=DEFAULT_DIV, en_q=DEFAULT_EN, pending=0, clk_out=0, tick_half=0, tick_rise=0.
- Counting, en_q=1: cnt!=div_q -> cnt+1. cnt==div_q (terminal) -> cnt=0, clk_out toggles, tick_half=1, tick_rise=1 iff clk_out was 0. Ticks are 0 on all other cycles.
- div_q=0: clk_out toggles every cycle, tick_half held high.
- Config accept: cfg_valid & cfg_ready. Writes with cfg_chan >= CHANNELS are accepted and ignored.
- Accepted write, cfg_en=0: immediate. Next edge gives en_q=0, cnt=0, clk_out=0, ticks=0, div_q=cfg_div, pending=0. Disabled channel is frozen.
- Accepted write, channel disabled, cfg_en=1: immediate. div_q=cfg_div, en_q=1, cnt=0. Counting starts next cycle.
- Accepted write, channel enabled, cfg_en=1: shadow_div=cfg_div, pending=1. At the next terminal: div_q=shadow_div, pending=0, toggle still occurs. The half-period after that uses the new divisor.
- Write on the same edge as a terminal: the terminal uses the old div_q, and the shadow applies at the following terminal.
- While pending=1, cfg_ready=0 for that channel only. Other channels remain writable.
- Arithmetic: unsigned; cnt never exceeds div_q, so there is no wrap-around.

## Timing
- Half period = div_q+1 cycles; full period = 2*(div_q+1); duty exactly 50 %.
- After reset deassertion, first toggle at rising edge DEFAULT_DIV+1.
- All outputs except cfg_ready are registered; ticks coincide with the clk_out edge.
- Reset asserted mid-count: outputs return to reset values asynchronously, and pending updates are discarded.
- Configuration latency: immediate writes take effect on the accepting edge. Shadow writes take effect at the next terminal, at most div_q+1 cycles later.

## Test plan
- DEFAULT_DIV=3, CHANNELS=2: release reset -> clk_out[0] rises at edge 4, falls at edge 8, period 8; tick_rise every 8 cycles, tick_half every 4.
- Channel 1 enabled, div 3, write cfg_div=1 mid half-period -> pending=1, cfg_ready=0 for chan 1 and 1 for chan 0. The current half-period stays 4 cycles, then half-periods are 2 cycles and pending clears.
- Write cfg_en=0 to chan 0 -> next edge clk_out[0]=0, ticks 0, held 20 cycles; write cfg_en=1, div 0 -> toggles every cycle.
- Write landing exactly on the terminal edge -> old divisor for one more half-period, then the new one.
- Assert reset mid-count with pending=1 -> clk_out=0, pending=0 immediately. Release -> first toggle at DEFAULT_DIV+1.
- cfg_chan=3 with CHANNELS=2 -> accepted (cfg_ready=1), no channel changes.

Source files
------------

// File: rtl/clock_divider_bank.sv
// Bank of independent runtime-programmable clock dividers producing 50% square
// waves with toggle/rise tick strobes and glitch-free shadowed divisor updates.
module clock_divider_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned DEFAULT_DIV = 25000000,
  parameter bit          DEFAULT_EN  = 1'b1,
  localparam int unsigned CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_en,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick_half,
  output logic [CHANNELS-1:0] tick_rise,
  output logic [CHANNELS-1:0] pending
);

  // Zero-padded to the full cfg_chan range so out-of-range writes read as ready.
  logic [(2**CHAN_W)-1:0] pend_ext;

  always_comb begin
    pend_ext                 = '0;
    pend_ext[CHANNELS-1:0]   = pending;
    cfg_ready                = !pend_ext[cfg_chan];
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic             sel;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] shadow_q;
    logic             en_q;
    logic             pend_q;
    logic             clk_q;
    logic             half_q;
    logic             rise_q;

    assign sel = cfg_valid && cfg_ready && (cfg_chan == CHAN_W'(i));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q    <= '0;
        div_q    <= WIDTH'(DEFAULT_DIV);
        shadow_q <= '0;
        en_q     <= DEFAULT_EN;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        half_q   <= 1'b0;
        rise_q   <= 1'b0;
      end else begin
        half_q <= 1'b0;
        rise_q <= 1'b0;
        if (sel && !cfg_en) begin
          en_q   <= 1'b0;
          cnt_q  <= '0;
          clk_q  <= 1'b0;
          div_q  <= cfg_div;
          pend_q <= 1'b0;
        end else if (sel && !en_q) begin
          en_q  <= 1'b1;
          cnt_q <= '0;
          div_q <= cfg_div;
        end else if (en_q) begin
          if (cnt_q == div_q) begin
            cnt_q  <= '0;
            clk_q  <= !clk_q;
            half_q <= 1'b1;
            rise_q <= !clk_q;
            if (pend_q) begin
              div_q  <= shadow_q;
              pend_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
          end
          // A write can only be accepted with pend_q clear, so this never
          // collides with the shadow apply above; a same-edge terminal keeps div_q.
          if (sel) begin
            shadow_q <= cfg_div;
            pend_q   <= 1'b1;
          end
        end
      end
    end

    assign clk_out[i]   = clk_q;
    assign tick_half[i] = half_q;
    assign tick_rise[i] = rise_q;
    assign pending[i]   = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: directed vector table, corner-case sequences
// and randomized traffic against an event-time reference model.
module tb_clock_divider_bank;
  localparam int unsigned CH   = 3;
  localparam int unsigned W    = 8;
  localparam int unsigned DDIV = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_chan = '0;
  logic [W-1:0]  cfg_div = '0;
  logic          cfg_en = 1'b0;
  logic [CH-1:0] clk_out, tick_half, tick_rise, pending;

  int vectors = 0;
  int miscompares = 0;

  clock_divider_bank #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .DEFAULT_DIV(DDIV),
    .DEFAULT_EN (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_en   (cfg_en),
    .clk_out  (clk_out),
    .tick_half(tick_half),
    .tick_rise(tick_rise),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each enabled channel holds the absolute edge number of its
  // next toggle; a half period spans div+1 edges.
  bit          m_en[CH], m_pend[CH], m_lvl[CH];
  int unsigned m_div[CH], m_shadow[CH], m_next[CH];
  int unsigned cyc;
  bit [CH-1:0] e_th, e_tr;

  function automatic void model_reset();
    cyc = 0;
    for (int i = 0; i < CH; i++) begin
      m_en[i] = 1'b1; m_pend[i] = 1'b0; m_lvl[i] = 1'b0;
      m_div[i] = DDIV; m_shadow[i] = 0; m_next[i] = DDIV + 1;
    end
    e_th = '0; e_tr = '0;
  endfunction

  function automatic bit model_ready(int unsigned ch);
    return (ch >= CH) ? 1'b1 : !m_pend[ch];
  endfunction

  function automatic void model_edge(bit v, int unsigned ch, int unsigned d, bit e);
    bit acc;
    acc = v && model_ready(ch);
    cyc++;
    e_th = '0; e_tr = '0;
    for (int i = 0; i < CH; i++) begin
      if (acc && ch == i && !e) begin
        m_en[i] = 1'b0; m_lvl[i] = 1'b0; m_div[i] = d; m_pend[i] = 1'b0;
      end else if (acc && ch == i && !m_en[i]) begin
        m_en[i] = 1'b1; m_div[i] = d; m_next[i] = cyc + d + 1;
      end else if (m_en[i]) begin
        if (cyc == m_next[i]) begin
          m_lvl[i] = !m_lvl[i];
          e_th[i] = 1'b1;
          e_tr[i] = m_lvl[i];
          if (m_pend[i]) begin
            m_div[i] = m_shadow[i];
            m_pend[i] = 1'b0;
          end
          m_next[i] = cyc + m_div[i] + 1;
        end
        if (acc && ch == i) begin
          m_shadow[i] = d; m_pend[i] = 1'b1;
        end
      end
    end
  endfunction

  function automatic bit [CH-1:0] exp_lvl();
    for (int i = 0; i < CH; i++) exp_lvl[i] = m_lvl[i];
  endfunction

  function automatic bit [CH-1:0] exp_pend();
    for (int i = 0; i < CH; i++) exp_pend[i] = m_pend[i];
  endfunction

  task automatic step(input bit v, input int unsigned ch, input int unsigned d, input bit e);
    cfg_valid = v; cfg_chan = ch[1:0]; cfg_div = d[W-1:0]; cfg_en = e;
    #1;
    chk("cfg_ready", cfg_ready, model_ready(ch));
    @(posedge clk); #1;
    model_edge(v, ch, d, e);
    chk("clk_out", clk_out, exp_lvl());
    chk("tick_half", tick_half, e_th);
    chk("tick_rise", tick_rise, e_tr);
    chk("pending", pending, exp_pend());
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_pending", pending, 0);
    chk("rst_tick_half", tick_half, 0);
    chk("rst_tick_rise", tick_rise, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          v;
    bit [1:0]    ch;
    bit [W-1:0]  d;
    bit          e;
    bit          rdy;
    bit [CH-1:0] x_clk, x_th, x_tr, x_pd;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int first;
    tbl[0]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{1'b1, 2'd1, 8'd1, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 3'b010};
    tbl[2]  = '{1'b1, 2'd1, 8'd0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b010};
    tbl[3]  = '{1'b1, 2'd3, 8'd0, 1'b0, 1'b1, 3'b111, 3'b111, 3'b111, 3'b000};
    tbl[4]  = '{1'b1, 2'd0, 8'd0, 1'b0, 1'b1, 3'b110, 3'b000, 3'b000, 3'b000};
    tbl[5]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 3'b100, 3'b010, 3'b000, 3'b000};
    tbl[6]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 3'b100, 3'b000, 3'b000, 3'b000};
    tbl[7]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 3'b010, 3'b110, 3'b010, 3'b000};
    tbl[8]  = '{1'b1, 2'd0, 8'd0, 1'b1, 1'b1, 3'b010, 3'b000, 3'b000, 3'b000};
    tbl[9]  = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 3'b001, 3'b011, 3'b001, 3'b000};
    tbl[10] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 3'b000, 3'b001, 3'b000, 3'b000};
    tbl[11] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 3'b111, 3'b111, 3'b111, 3'b000};

    do_reset();
    for (int r = 0; r < 12; r++) begin
      cfg_valid = tbl[r].v; cfg_chan = tbl[r].ch; cfg_div = tbl[r].d; cfg_en = tbl[r].e;
      #1;
      chk($sformatf("tbl%0d_ready", r), cfg_ready, tbl[r].rdy);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      chk($sformatf("tbl%0d_clk_out", r), clk_out, tbl[r].x_clk);
      chk($sformatf("tbl%0d_tick_half", r), tick_half, tbl[r].x_th);
      chk($sformatf("tbl%0d_tick_rise", r), tick_rise, tbl[r].x_tr);
      chk($sformatf("tbl%0d_pending", r), pending, tbl[r].x_pd);
    end

    // Write landing on the terminal edge of channel 2: old divisor holds one more half period.
    do_reset();
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    step(1, 2, 0, 1);
    chk("term_wr_clk2_e4", clk_out[2], 1);
    chk("term_wr_pend2_e4", pending[2], 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("term_wr_clk2_e8", clk_out[2], 0);
    chk("term_wr_pend2_e8", pending[2], 0);
    step(0, 0, 0, 0);
    chk("term_wr_clk2_e9", clk_out[2], 1);
    step(0, 0, 0, 0);
    chk("term_wr_clk2_e10", clk_out[2], 0);

    // Disabled channel stays frozen low, then divisor 0 toggles every cycle.
    step(1, 0, 5, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 0);
      chk("dis_hold_clk0", clk_out[0], 0);
    end
    step(1, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      chk("div0_tick_half0", tick_half[0], 1);
    end

    // Asynchronous reset mid-count with a pending shadow update.
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
    step(1, 1, 2, 1);
    chk("pre_rst_pend1", pending[1], 1);
    do_reset();
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      step(0, 0, 0, 0);
      if (clk_out[0]) first = k;
    end
    chk("first_toggle_edge", first, DDIV + 1);

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 3), $urandom_range(0, 6),
           $urandom_range(0, 9) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
